// File: rtl/lab_pkg.sv
// Shared constants for the lab datapath blocks: operating-mode encodings
// for the universal shift register family.
package lab_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR   = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROR   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL   = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ASR   = 3'b101;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b111;

endpackage : lab_pkg

// File: rtl/shift_counter.sv
// Saturating up-counter with synchronous clear and a registered
// "at limit" flag that always agrees with the registered count.
module shift_counter #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit_q, at_limit_d;

    // Next count: clear has priority over increment; increment stops at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != LIMIT_V)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        at_limit_d = (cnt_d == LIMIT_V);
    end

    // Count and flag registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            at_limit_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = at_limit_q;

endmodule : shift_counter

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, logical/arithmetic shifts,
// rotates, parallel load and synchronous clear, with a registered
// complement output and a saturating count of bits shifted out.
module universal_shift_register
    import lab_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [MODE_W-1:0] Mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              Ser_In_R,
    input  logic              Ser_In_L,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Q_Bar,
    output logic              Ser_Out_R,
    output logic              Ser_Out_L,
    output logic [CNT_W-1:0]  Shift_Cnt,
    output logic              Drained
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_bar_q;
    logic             cnt_inc;
    logic             cnt_clr;

    // Data-path next state, selected by Mode; Enable low holds everything.
    always_comb begin
        q_d = q_q;
        if (Enable) begin
            case (Mode)
                MODE_HOLD:  q_d = q_q;
                MODE_SHR:   q_d = {Ser_In_R, q_q[WIDTH-1:1]};
                MODE_SHL:   q_d = {q_q[WIDTH-2:0], Ser_In_L};
                MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                MODE_LOAD:  q_d = D;
                MODE_CLEAR: q_d = '0;
                default:    q_d = q_q;
            endcase
        end
    end

    // Counter control: only data-losing shifts count; load/clear restart it.
    always_comb begin
        cnt_inc = (Mode == MODE_SHR) || (Mode == MODE_SHL) || (Mode == MODE_ASR);
        cnt_clr = (Mode == MODE_LOAD) || (Mode == MODE_CLEAR);
    end

    // State and its complement share one register block so they never disagree.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_q     <= '0;
            q_bar_q <= '1;
        end else begin
            q_q     <= q_d;
            q_bar_q <= ~q_d;
        end
    end

    shift_counter #(
        .CNT_W (CNT_W),
        .LIMIT (WIDTH)
    ) u_shift_counter (
        .clk      (Clk),
        .rst      (Reset),
        .en       (Enable),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .cnt      (Shift_Cnt),
        .at_limit (Drained)
    );

    assign Q         = q_q;
    assign Q_Bar     = q_bar_q;
    assign Ser_Out_R = q_q[0];
    assign Ser_Out_L = q_q[WIDTH-1];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register at WIDTH=8.
module tb_universal_shift_register;
    import lab_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic              clk;
    logic              reset;
    logic              enable;
    logic [MODE_W-1:0] mode;
    logic [WIDTH-1:0]  d;
    logic              ser_in_r;
    logic              ser_in_l;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  q_bar;
    logic              ser_out_r;
    logic              ser_out_l;
    logic [CNT_W-1:0]  shift_cnt;
    logic              drained;

    int checks = 0;
    int errors = 0;

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .Enable    (enable),
        .Mode      (mode),
        .D         (d),
        .Ser_In_R  (ser_in_r),
        .Ser_In_L  (ser_in_l),
        .Q         (q),
        .Q_Bar     (q_bar),
        .Ser_Out_R (ser_out_r),
        .Ser_Out_L (ser_out_l),
        .Shift_Cnt (shift_cnt),
        .Drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Apply one operation for one clock edge, then settle past the edge.
    task automatic op(input logic [MODE_W-1:0] m, input logic [WIDTH-1:0] din,
                      input logic sr, input logic sl, input logic en);
        mode     = m;
        d        = din;
        ser_in_r = sr;
        ser_in_l = sl;
        enable   = en;
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp_q;

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        mode     = MODE_HOLD;
        d        = '0;
        ser_in_r = 1'b0;
        ser_in_l = 1'b0;
        #2;
        check_val("rst_q", q, 8'h00);
        check_val("rst_qbar", q_bar, 8'hFF);
        check_val("rst_cnt", shift_cnt, 0);
        check_val("rst_drained", drained, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset mid-stream after a load
        op(MODE_LOAD, 8'hA5, 1'b0, 1'b0, 1'b1);
        op(MODE_SHR, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("pre_async_q", q, 8'h52);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_q", q, 8'h00);
        check_val("async_qbar", q_bar, 8'hFF);
        check_val("async_cnt", shift_cnt, 0);
        check_val("async_drained", drained, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // LOAD then SHR with Ser_In_R=1
        op(MODE_LOAD, 8'hB4, 1'b0, 1'b0, 1'b1);
        check_val("shr_load", q, 8'hB4);
        check_val("shr_so0", ser_out_r, 1'b0);
        op(MODE_SHR, 8'h00, 1'b1, 1'b0, 1'b1);
        check_val("shr_q1", q, 8'hDA);
        check_val("shr_so1", ser_out_r, 1'b0);
        op(MODE_SHR, 8'h00, 1'b1, 1'b0, 1'b1);
        check_val("shr_q2", q, 8'hED);
        check_val("shr_so2", ser_out_r, 1'b1);
        op(MODE_SHR, 8'h00, 1'b1, 1'b0, 1'b1);
        check_val("shr_q3", q, 8'hF6);
        check_val("shr_cnt", shift_cnt, 3);
        check_val("shr_qbar", q_bar, 8'h09);

        // HOLD keeps data and count
        op(MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("hold_q", q, 8'hF6);
        check_val("hold_cnt", shift_cnt, 3);

        // LOAD then ROL x2
        op(MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b1);
        check_val("rol_sol", ser_out_l, 1'b1);
        check_val("rol_cnt0", shift_cnt, 0);
        op(MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("rol_q1", q, 8'h03);
        op(MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("rol_q2", q, 8'h06);
        check_val("rol_cnt", shift_cnt, 0);

        // ROR wraps LSB into MSB
        op(MODE_LOAD, 8'h81, 1'b0, 1'b0, 1'b1);
        op(MODE_ROR, 8'h00, 1'b1, 1'b1, 1'b1);
        check_val("ror_q", q, 8'hC0);
        check_val("ror_cnt", shift_cnt, 0);

        // LOAD then ASR x2; Ser_In_R ignored
        op(MODE_LOAD, 8'h90, 1'b0, 1'b0, 1'b1);
        op(MODE_ASR, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("asr_q1", q, 8'hC8);
        op(MODE_ASR, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("asr_q2", q, 8'hE4);
        check_val("asr_qbar", q_bar, 8'h1B);
        check_val("asr_cnt", shift_cnt, 2);

        // SHL with Ser_In_L=1 fills from LSB
        op(MODE_LOAD, 8'h40, 1'b0, 1'b0, 1'b1);
        op(MODE_SHL, 8'h00, 1'b0, 1'b1, 1'b1);
        check_val("shl1_q", q, 8'h81);

        // LOAD FF, SHL with 0 for 10 cycles: drain and saturate
        op(MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            op(MODE_SHL, 8'h00, 1'b0, 1'b0, 1'b1);
            exp_q = 8'hFF << k;
            check_val($sformatf("drain_q%0d", k), q, exp_q);
            check_val($sformatf("drain_cnt%0d", k), shift_cnt, (k < 8) ? k : 8);
            check_val($sformatf("drain_dr%0d", k), drained, (k >= 8) ? 1'b1 : 1'b0);
        end

        // Enable=0 holds everything even with LOAD selected
        for (int k = 0; k < 4; k++) begin
            op(MODE_LOAD, 8'h5A, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("en0_q%0d", k), q, 8'h00);
            check_val($sformatf("en0_cnt%0d", k), shift_cnt, 8);
            check_val($sformatf("en0_dr%0d", k), drained, 1'b1);
        end
        op(MODE_CLEAR, 8'h5A, 1'b0, 1'b0, 1'b1);
        check_val("clr_q", q, 8'h00);
        check_val("clr_cnt", shift_cnt, 0);
        check_val("clr_dr", drained, 1'b0);

        // CLEAR wipes non-zero data
        op(MODE_LOAD, 8'h3C, 1'b0, 1'b0, 1'b1);
        op(MODE_SHR, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("clr2_pre", q, 8'h1E);
        op(MODE_CLEAR, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("clr2_q", q, 8'h00);
        check_val("clr2_qbar", q_bar, 8'hFF);
        check_val("clr2_cnt", shift_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_universal_shift_register
